// File: rtl/labfinalsoc_usb_irq_pio.sv
// Avalon-MM input PIO: synchronizes external status lines, captures configured edges into a
// sticky W1C register and raises a level interrupt for any captured, unmasked bit.
module labfinalsoc_usb_irq_pio #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] PrimeCycles = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [2:0]       prime_q;
  logic             primed;
  logic             wr_en;
  logic [31:0]      readdata_d;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign primed = (prime_q == PrimeCycles);
  assign wr_en  = chipselect && !write_n;
  assign rise   = sync & ~prev_q;
  assign fall   = ~sync & prev_q;
  assign clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Edges are ignored until the chain and prev hold post-reset samples.
  always_comb begin
    det = '0;
    if (primed) begin
      case (EDGE_TYPE)
        0:       det = rise;
        1:       det = fall;
        default: det = rise | fall;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d[WIDTH-1:0] = sync;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      prime_q  <= '0;
      readdata <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q   <= sync;
      prime_q  <= primed ? prime_q : prime_q + 3'd1;
      cap_q    <= (cap_q & ~clr) | det;
      readdata <= readdata_d;
      if (wr_en && address == 2'd2) begin
        mask_q <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(cap_q & mask_q);

endmodule

// File: doc/labfinalsoc_usb_irq_pio.md
# labfinalsoc_usb_irq_pio

Avalon-MM slave input port with edge capture and interrupt generation; the input-direction counterpart of the USB control output PIOs in the SoC. It synchronizes the USB controller's interrupt line (and any other `WIDTH`-bit external status inputs) into `clk`, latches configured edges into a sticky capture register, and raises `irq` to the Nios II when any captured, unmasked bit is set. Software reads the live level, programs the mask, and clears captures by write-1-to-clear.

## Interface
Parameters:
- `WIDTH`, 1: number of input bits (1..32).
- `SYNC_STAGES`, 2: synchronizer flops per bit (2..4).
- `EDGE_TYPE`, 0: 0 = rising, 1 = falling, 2 = any edge.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits above `WIDTH` ignored.
- `in_port`  in  `WIDTH`  asynchronous external inputs.
- `readdata`  out  32  registered read data, zero-extended.
- `irq`  out  1  level interrupt to CPU.

## Operation
- Register map:
  - 0 DATA (RO): synchronized level of `in_port`.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAP (R/W1C): sticky captured edges.
- Write occurs when `chipselect && !write_n`. Writes to address 0 and 1 have no effect.
- Synchronizer: `SYNC_STAGES` flops per bit; output `sync`. `prev` register holds `sync` from the previous cycle.
- Edge detect: `rise = sync & ~prev`, `fall = ~sync & prev`. `EDGE_TYPE` selects rise, fall, or rise|fall.
- Prime counter: after reset, edge detection is suppressed until the chain has filled. This means `SYNC_STAGES + 1` cycles, which prevents a false edge when an input is already high at reset. The counter saturates; it is reset only by `reset`.
- EDGECAP bit update per cycle: `cap <= (cap & ~clr) | det`.
  - `clr` = `writedata` bits on a valid write to address 3.
  - `det` = qualified edge.
  - Set wins over a simultaneous clear of the same bit.
- `irq = |(EDGECAP & IRQMASK)`, combinational from flops only. It stays high until software clears the bits or masks them.
- `readdata` is registered every cycle from `address` regardless of `chipselect`. Upper `32-WIDTH` bits are 0.
- Reset values:
  - sync chain, `prev`, IRQMASK, EDGECAP, prime counter, `readdata`: 0.
  - `irq`: 0.

## Timing
- Read latency: 1 cycle. `readdata` reflects the `address` presented at the previous rising edge. The Avalon interface is configured with 1 read wait state.
- Write: takes effect at the rising edge where it is asserted. A read of the same register on the next cycle returns the new value.
- Input to capture: `in_port` change sampled at edge k appears on `sync` after edge k+`SYNC_STAGES`-1. The EDGECAP bit sets at edge k+`SYNC_STAGES`, and `irq` rises in the same cycle if the bit is unmasked. With defaults, this is 2 cycles from sampling to `irq`.
- Pulses shorter than one `clk` period may be missed. Pulses of at least 2 periods are guaranteed captured.
- Masking: IRQMASK write at edge n gates `irq` from edge n. EDGECAP is unaffected by the mask, so captures still accumulate.
- Reset asserted mid-operation: all state clears at the next edge and the prime window restarts. Input edges during reset or the prime window are lost.

## Test plan
- Reset with `in_port`=1 held, defaults: no EDGECAP bit set and `irq`=0 for 20 cycles after release; DATA reads 1.
- IRQMASK=1, `in_port` 0→1 sampled at edge k: EDGECAP[0]=1 and `irq`=1 after edge k+2; write 0x1 to address 3 → `irq`=0 next cycle, EDGECAP reads 0.
- `EDGE_TYPE`=1, `in_port` 0→1 then 1→0: only the falling edge sets EDGECAP; `EDGE_TYPE`=2 sets on both.
- New edge detected in the same cycle as W1C of that bit: EDGECAP stays 1 and `irq` stays high.
- IRQMASK=0, edge occurs: EDGECAP=1, `irq`=0; write IRQMASK=1 → `irq`=1 at that edge. Reads of addresses 1 and 2 return 0x0 and 0x1 with 1-cycle latency.
- `WIDTH`=4: independent edges on bits 0 and 3 → EDGECAP=0x9; W1C 0x8 → 0x1; writes to address 0 do not alter DATA.
